// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, reset PC
// default and small arithmetic helpers.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// Combinational next-PC selection: sequential pc+4, branch target or jump target.
module next_pc_sel
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] ir_pc,
  input  logic        ir_valid,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] seq_pc,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  logic [31:0] link_pc;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    seq_pc      = pc + PC_STEP;
    link_pc     = ir_pc + PC_STEP;
    redirect    = ir_valid & (jump | branch_taken);
    redirect_pc = link_pc + (branch_offset << 2);
    if (jump) begin
      redirect_pc = {link_pc[31:28], jump_index, 2'b00};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: BOOT/RUN/HALT sequencer, PC and instruction register
// with stall, branch/jump redirect and a saturating issue counter.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
  parameter int          IMEM_WORDS_LOG2 = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [IMEM_WORDS_LOG2-1:0] pc_5bits,
  output logic                       memRead,
  input  logic [31:0]                instr_in,
  input  logic                       stall,
  input  logic                       branch_taken,
  input  logic [31:0]                branch_offset,
  input  logic                       jump,
  input  logic [25:0]                jump_index,
  input  logic                       halt,
  output logic [31:0]                pc,
  output logic [31:0]                ir_out,
  output logic [31:0]                ir_pc,
  output logic                       ir_valid,
  output logic [31:0]                fetch_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ir_q, ir_d;
  logic [31:0]  ir_pc_q, ir_pc_d;
  logic         ir_valid_q, ir_valid_d;
  logic [31:0]  count_q, count_d;

  logic [31:0]  seq_pc;
  logic         redirect;
  logic [31:0]  redirect_pc;

  next_pc_sel u_next_pc_sel (
    .pc            (pc_q),
    .ir_pc         (ir_pc_q),
    .ir_valid      (ir_valid_q),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .seq_pc        (seq_pc),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc)
  );

  // Priority in RUN: halt, then redirect (which also beats stall), then stall, then fetch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    count_d    = count_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (halt) begin
          state_d    = ST_HALT;
          ir_valid_d = 1'b0;
        end else if (redirect) begin
          pc_d       = redirect_pc;
          ir_valid_d = 1'b0;
        end else if (!stall) begin
          pc_d       = seq_pc;
          ir_d       = instr_in;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
          count_d    = sat_inc32(count_q);
        end
      end
      ST_HALT: ir_valid_d = 1'b0;
      default: state_d = ST_BOOT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      count_q    <= count_d;
    end
  end

  assign memRead     = (state_q == ST_RUN);
  assign pc_5bits    = pc_q[IMEM_WORDS_LOG2+1:2];
  assign pc          = pc_q;
  assign ir_out      = ir_q;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = ir_valid_q;
  assign fetch_count = count_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: byte address loaded into pc on reset.
REQ-002 SHALL have parameter IMEM_WORDS_LOG2, default 5: word-address width driven to instruction memory.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port pc_5bits  output  5: word address to instruction memory.
REQ-006 SHALL have port memRead  output  1: instruction-memory read enable.
REQ-007 SHALL have port instr_in  input  32: instruction word returned combinationally by instruction memory.
REQ-008 SHALL have port stall  input  1: decode back-pressure; hold pc and IR.
REQ-009 SHALL have port branch_taken  input  1: taken branch resolved for the instruction on ir_out.
REQ-010 SHALL have port branch_offset  input  32: sign-extended word offset of that branch.
REQ-011 SHALL have port jump  input  1: J-type jump for the instruction on ir_out.
REQ-012 SHALL have port jump_index  input  26: J-type target field.
REQ-013 SHALL have port halt  input  1: stop fetching permanently until reset.
REQ-014 SHALL have port pc  output  32: current fetch byte address.
REQ-015 SHALL have port ir_out  output  32: registered instruction for decode.
REQ-016 SHALL have port ir_pc  output  32: byte address of ir_out.
REQ-017 SHALL have port ir_valid  output  1: ir_out holds a live instruction.
REQ-018 SHALL have port fetch_count  output  32: number of instructions issued with ir_valid.

Function
REQ-019 SHALL implement FSM states BOOT, RUN, HALT; BOOT entered on reset.
REQ-020 BOOT SHALL last exactly one cycle with memRead=0, then go to RUN.
REQ-021 In RUN, memRead SHALL be 1; pc_5bits SHALL equal pc[IMEM_WORDS_LOG2+1:2].
REQ-022 In RUN with no stall and no redirect: ir_out<=instr_in, ir_pc<=pc, ir_valid<=1, pc<=pc+4 (1-cycle latency).
REQ-023 pc+4 SHALL wrap modulo 2^32; pc_5bits therefore wraps from 31 to 0.
REQ-024 Branch target SHALL be ir_pc+4+(branch_offset<<2), 32-bit modulo arithmetic.
REQ-025 Jump target SHALL be {(ir_pc+4)[31:28], jump_index, 2'b00}.
REQ-026 Redirect SHALL only be honoured when ir_valid=1; jump has priority over branch_taken.
REQ-027 On redirect: pc<=target, ir_valid<=0 next cycle (instruction fetched that cycle is flushed).
REQ-028 Redirect SHALL override a simultaneous stall.
REQ-029 On stall without redirect: pc, ir_out, ir_pc, ir_valid, fetch_count SHALL hold.
REQ-030 fetch_count SHALL increment when ir_valid rises or reloads with a new instruction; saturate at 32'hFFFF_FFFF.
REQ-031 halt in RUN SHALL move to HALT next edge; halt has priority over redirect and stall.
REQ-032 In HALT: memRead=0, ir_valid=0, pc and fetch_count frozen; exit only via reset.
REQ-033 halt during BOOT SHALL be ignored.

Reset
REQ-034 On reset low: state=BOOT, pc=RESET_PC, ir_out=0, ir_pc=0, ir_valid=0, fetch_count=0, immediately, regardless of clk.
REQ-035 Reset asserted mid-stall, mid-redirect or in HALT SHALL abandon all activity; no partial update after release.
REQ-036 First RUN fetch after reset release SHALL occur on the second rising edge.

Structure
REQ-037 FSM state encodings and RESET_PC default SHALL live in the shared mips definitions include file.
REQ-038 Next-pc selection (pc+4 / branch / jump) SHALL be a sub-module next_pc_sel, purely combinational.

Verification
REQ-039 Reset release, no stall, memory returns 0x2001_0005 at word 0: edge 2 -> ir_out=0x2001_0005, ir_pc=0, ir_valid=1, pc=4.
REQ-040 Run 33 sequential fetches -> pc_5bits wraps 31->0, pc=0x80 after 32 issues, fetch_count=32.
REQ-041 ir_pc=0x10, branch_taken=1, branch_offset=-2 -> pc=0x0C next edge, ir_valid=0 for one cycle.
REQ-042 ir_pc=0x10, jump=1, branch_taken=1, jump_index=0x000_0008 -> pc=0x20 (jump wins).
REQ-043 stall=1 for 3 cycles -> pc, ir_out, fetch_count unchanged; stall+jump same cycle -> redirect taken.
REQ-044 halt=1 at pc=0x14, then reset low mid-cycle -> HALT with memRead=0; async reset forces pc=0, ir_valid=0 without a clock edge.
